// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pc/instruction pipeline register with a 2-entry skid buffer and flush; optional PIPE_STAGE_PERF_EN adds stall/flush counters
module pipe_stage_skid #(
  parameter int PC_W = 32,
  parameter int INS_W = 32,
  parameter logic [INS_W-1:0] BUBBLE_INS = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_ins,
`ifdef PIPE_STAGE_PERF_EN
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`else
  output logic [1:0]       occ
`endif
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INS_W-1:0] main_ins_q, main_ins_d, skid_ins_q, skid_ins_d;
  logic             accept, take;
  // state and data registers; reset and flush leave both slots holding a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_pc_q  <= '0;
      main_ins_q <= BUBBLE_INS;
      skid_pc_q  <= '0;
      skid_ins_q <= BUBBLE_INS;
    end else begin
      state_q    <= state_d;
      main_pc_q  <= main_pc_d;
      main_ins_q <= main_ins_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
    end
  end
  // next state: flush wins, otherwise fill main first, spill to skid on stall, refill main from skid
  always_comb begin
    state_d    = state_q;
    main_pc_d  = main_pc_q;
    main_ins_d = main_ins_q;
    skid_pc_d  = skid_pc_q;
    skid_ins_d = skid_ins_q;
    if (flush) begin
      state_d    = EMPTY;
      main_pc_d  = '0;
      main_ins_d = BUBBLE_INS;
      skid_pc_d  = '0;
      skid_ins_d = BUBBLE_INS;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d    = ONE;
          main_pc_d  = in_pc;
          main_ins_d = in_ins;
        end
        ONE: if (accept && take) begin
          main_pc_d  = in_pc;
          main_ins_d = in_ins;
        end else if (accept) begin
          state_d    = FULL;
          skid_pc_d  = in_pc;
          skid_ins_d = in_ins;
        end else if (take) begin
          state_d    = EMPTY;
          main_pc_d  = '0;
          main_ins_d = BUBBLE_INS;
        end
        FULL: if (take) begin
          state_d    = ONE;
          main_pc_d  = skid_pc_q;
          main_ins_d = skid_ins_q;
          skid_pc_d  = '0;
          skid_ins_d = BUBBLE_INS;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // outputs decode from registers only, so in_ready never depends on out_ready
  always_comb begin
    in_ready  = state_q != FULL;
    out_valid = state_q != EMPTY;
    out_pc    = main_pc_q;
    out_ins   = main_ins_q;
    occ       = state_q;
    accept    = in_valid && in_ready;
    take      = out_valid && out_ready;
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // saturating stall and flush counters, untouched by flush itself
  always_comb begin
    stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end
  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid; beats pushed on accept, popped and compared when presented
module tb_pipe_stage_skid;
  localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int exp_stall, exp_flush;
`endif
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_ins, out_pc, out_ins;
  logic [1:0] occ;
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;
  bit cap;
  int checks, errors;

  pipe_stage_skid #(.PC_W(32), .INS_W(32), .BUBBLE_INS(BUB)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ins(out_ins),
`ifdef PIPE_STAGE_PERF_EN
    .occ(occ), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .occ(occ)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, r, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return (pc * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  // monitor: state checks every cycle; pop and compare the presented beat
  always @(negedge clk) if (!rst) begin
    chk("occ", 64'(occ), 64'(exp_q.size()));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
    if (exp_q.size() > 0 && !out_ready && exp_stall < CMAX) exp_stall++;
`endif
    cap = exp_q.size() < 2;
    if (exp_q.size() > 0) begin
      chk("out_pc", 64'(out_pc), 64'(exp_q[0][63:32]));
      chk("out_ins", 64'(out_ins), 64'(exp_q[0][31:0]));
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      chk("bubble_pc", 64'(out_pc), 64'd0);
      chk("bubble_ins", 64'(out_ins), 64'(BUB));
    end
  end

  // stimulus tracker: record accepted beats, drop everything on flush
  always @(posedge clk) if (!rst) begin
    if (flush) begin
      exp_q.delete();
      if (in_valid) next_pc += 4;
`ifdef PIPE_STAGE_PERF_EN
      if (exp_flush < CMAX) exp_flush++;
`endif
    end else if (in_valid && cap) begin
      exp_q.push_back({in_pc, in_ins});
      next_pc += 4;
    end
  end

  task automatic cyc(input bit v, input bit r, input bit f);
    in_valid = v; out_ready = r; flush = f;
    in_pc = next_pc; in_ins = ins_of(next_pc);
    @(posedge clk); #1;
  endtask

  task automatic async_rst(input logic [31:0] pc0);
    in_valid = 0; flush = 0;
    #1 rst = 1;
    exp_q.delete();
    cap = 1;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 0; exp_flush = 0;
`endif
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ins", 64'(out_ins), 64'(BUB));
    #1 rst = 0;
    next_pc = pc0;
  endtask

  initial begin
    checks = 0; errors = 0; cap = 1; next_pc = 0;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 0; exp_flush = 0;
`endif
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_ins = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_occ", 64'(occ), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_pc", 64'(out_pc), 64'd0);
    chk("reset_out_ins", 64'(out_ins), 64'(BUB));
    rst = 0;
    repeat (8) cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    repeat (5) cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_out_ins", 64'(out_ins), 64'(BUB));
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (2) cyc(0, 1, 0);
    chk("drain_out_pc", 64'(out_pc), 64'd0);
    repeat (3) cyc(1, 0, 0);
    async_rst(32'h100);
    cyc(1, 1, 0);
    chk("post_rst_pc", 64'(out_pc), 64'h100);
    repeat (3) cyc(0, 1, 0);
    repeat (600) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
`ifdef PIPE_STAGE_PERF_EN
    async_rst(32'h200);
    repeat (20) cyc(1, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'hF);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("flush_cnt2", 64'(flush_cnt), 64'd2);
`endif
    repeat (4) cyc(0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
